// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and elaboration-time helpers for the PWM generator.
// Everything here is evaluated at elaboration only; nothing in this package
// turns into logic by itself.
package pwm_pkg;

  // Duty is given in integer percent, so 100 is the largest meaningful value.
  localparam int DUTY_MAX = 100;

  // Smallest and largest period (in clk_pwm cycles) the generator supports.
  localparam longint F_MIN = 2;
  localparam longint F_MAX = 64'd2147483647;

  // Number of cycles per period during which PWM is high.
  // The multiply is done in 64 bits so that a large period times 100 cannot
  // overflow. The divide truncates toward zero, so for example f=3 at 50 %
  // gives one high cycle.
  function automatic longint pwm_high_cnt(input longint f, input longint duty);
    return (f * duty) / longint'(DUTY_MAX);
  endfunction

  // Width of the period counter. It must hold values 0..f-1. The width is
  // never allowed to drop below one bit.
  function automatic int pwm_cw(input longint f);
    int w;
    w = $clog2(f);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// pwm_period_counter: free-running modulo-f counter for the PWM generator.
// The counter counts 0..f-1 and returns to 0 with no extra or missing cycle.
// rst_n is a synchronous, active-low clear. The wrap output is high while the
// counter sits on its last value (f-1).
module pwm_period_counter
  import pwm_pkg::*;
#(
  parameter int f  = 10000,
  parameter int CW = pwm_cw(longint'(f))
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  // Terminal count, pre-sized to the counter width.
  localparam logic [CW-1:0] LAST = CW'(f - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: wrap to zero on the terminal value, otherwise increment.
  always_comb begin
    wrap  = (cnt_q == LAST);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  // Counter register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: fixed-period, fixed-duty PWM generator.
// A free-running period counter is compared against an elaboration-time
// high count. The comparison result is registered onto PWM, so PWM lags the
// counter by exactly one cycle.
// Optional build macro PWM_SYNC_OUT_EN adds the registered pwm_sync output.
// pwm_sync is a one-cycle pulse on the first cycle of every PWM period.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int f    = 10000,
  parameter int duty = 50
) (
  input  logic clk_pwm,
  input  logic clr_pwm,
`ifdef PWM_SYNC_OUT_EN
  output logic pwm_sync,
`endif
  output logic PWM
);

  localparam longint HIGH_CNT = pwm_high_cnt(longint'(f), longint'(duty));
  localparam int     CW       = pwm_cw(longint'(f));

  // HIGH_CNT can equal f at 100 % duty, which needs one bit more than the
  // counter. The compare is therefore done at width CW+1.
  localparam logic [CW:0] HIGH_W = (CW + 1)'(HIGH_CNT);

  // Reject illegal configurations while the design is being built.
  if (longint'(f) < F_MIN || longint'(f) > F_MAX) begin : g_bad_f
    $fatal(1, "pwm_gen: period f=%0d outside legal range 2..2^31-1", f);
  end
  if (duty < 0 || duty > DUTY_MAX) begin : g_bad_duty
    $fatal(1, "pwm_gen: duty=%0d outside legal range 0..100", duty);
  end

  logic [CW-1:0] cnt;
  // The wrap flag is not needed here. The sync pulse decodes cnt==0 directly,
  // so it is also correct in the first cycle after reset.
  logic          cnt_wrap_unused;

  pwm_period_counter #(
    .f  (f),
    .CW (CW)
  ) u_cnt (
    .clk   (clk_pwm),
    .rst_n (clr_pwm),
    .cnt   (cnt),
    .wrap  (cnt_wrap_unused)
  );

  logic pwm_q;
  logic pwm_d;

  // The output is high while the counter is below the high count.
  always_comb begin
    pwm_d = ({1'b0, cnt} < HIGH_W);
  end

  // Output flop. It clears synchronously so no partial pulse survives a reset.
  always_ff @(posedge clk_pwm) begin
    if (!clr_pwm) pwm_q <= 1'b0;
    else          pwm_q <= pwm_d;
  end

  assign PWM = pwm_q;

`ifdef PWM_SYNC_OUT_EN
  logic sync_q;
  logic sync_d;

  // Period-start marker. It lines up with PWM's first cycle of each period.
  always_comb begin
    sync_d = (cnt == '0);
  end

  // Sync flop. It uses the same run condition as the PWM output.
  always_ff @(posedge clk_pwm) begin
    if (!clr_pwm) sync_q <= 1'b0;
    else          sync_q <= sync_d;
  end

  assign pwm_sync = sync_q;
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: randomized and directed check of several pwm_gen configurations
// that share one clock and one clear. The expected waveform comes from k, the
// number of running edges since the last reset edge. After running edge k,
// PWM = ((k-1) mod f) < floor(f*duty/100), and pwm_sync = ((k-1) mod f) == 0.
module tb_pwm_gen;

  localparam int N = 6;

  function automatic int cfg_f(input int i);
    case (i)
      0: return 1000;
      1: return 10;
      2: return 3;
      3: return 8;
      4: return 8;
      default: return 10;
    endcase
  endfunction

  function automatic int cfg_d(input int i);
    case (i)
      0: return 90;
      1: return 50;
      2: return 50;
      3: return 0;
      4: return 100;
      default: return 30;
    endcase
  endfunction

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic [N-1:0] pwm;
`ifdef PWM_SYNC_OUT_EN
  logic [N-1:0] sync;
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    pwm_gen #(
      .f    (cfg_f(g)),
      .duty (cfg_d(g))
    ) u_dut (
      .clk_pwm  (clk),
      .clr_pwm  (clr),
`ifdef PWM_SYNC_OUT_EN
      .pwm_sync (sync[g]),
`endif
      .PWM      (pwm[g])
    );
  end

  int total = 0;
  int bad   = 0;
  int k     = 0;   // running edges since the last reset edge (0 = in reset)
  int hi0   = 0;

  // Reference model: compute the expected level from the period position.
  function automatic logic exp_pwm(input int i, input int kk);
    int ff, hh;
    ff = cfg_f(i);
    hh = int'((longint'(ff) * longint'(cfg_d(i))) / 100);
    if (kk == 0) return 1'b0;
    return (((kk - 1) % ff) < hh);
  endfunction

  task automatic check_all();
    logic e;
    for (int i = 0; i < N; i++) begin
      e = exp_pwm(i, k);
      total++;
      assert (pwm[i] === e) else begin
        bad++;
        $error("FAIL pwm[%0d] f=%0d duty=%0d k=%0d got=%b exp=%b",
               i, cfg_f(i), cfg_d(i), k, pwm[i], e);
      end
`ifdef PWM_SYNC_OUT_EN
      e = (k != 0) && (((k - 1) % cfg_f(i)) == 0);
      total++;
      assert (sync[i] === e) else begin
        bad++;
        $error("FAIL sync[%0d] k=%0d got=%b exp=%b", i, k, sync[i], e);
      end
`endif
    end
  endtask

  // Drive clr, take one rising edge, advance the model, and check at +1.
  task automatic step(input logic c);
    clr = c;
    @(posedge clk);
    if (c) k++;
    else   k = 0;
    #1;
    check_all();
  endtask

  initial begin
    // Hold reset for 20 cycles; every output must stay 0.
    repeat (20) step(1'b0);

    // Three full periods of the f=1000 instance. All other instances are
    // checked alongside it.
    for (int c = 0; c < 3000; c++) begin
      step(1'b1);
      if (c >= 1000 && c < 2000 && pwm[0]) hi0++;
    end
    total++;
    assert (hi0 == 900) else begin
      bad++;
      $error("FAIL hicount f=1000 got=%0d exp=900", hi0);
    end

    // Advance to cnt=450 (PWM high), then pulse reset for one cycle.
    repeat (450) step(1'b1);
    step(1'b0);
    repeat (1100) step(1'b1);

    // Random run lengths separated by random short resets.
    for (int s = 0; s < 12; s++) begin
      repeat ($urandom_range(1, 3)) step(1'b0);
      repeat ($urandom_range(1, 400)) step(1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
